// File: rtl/servo_pwm_bank.sv
// Four-channel servo PWM generator with double-buffered pulse widths that swap at each frame boundary.
// Optional build macro SERVO_PWM_CLAMP_EN limits written widths to 500..2500 us.
module servo_pwm_bank #(
  parameter int unsigned TICKS_PER_US = 100,
  parameter int unsigned FRAME_US     = 20000,
  parameter int unsigned RESET_US     = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [1:0]  addr,
  input  logic [15:0] data,
  output logic [3:0]  signal,
  output logic        frame_sync
);

  localparam logic [15:0] TICK_LAST  = 16'(TICKS_PER_US - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_US - 1);
  localparam logic [15:0] RESET_VAL  = 16'(RESET_US);

  function automatic logic [15:0] clamp_width(input logic [15:0] w);
`ifdef SERVO_PWM_CLAMP_EN
    if (w < 16'd500)
      return 16'd500;
    else if (w > 16'd2500)
      return 16'd2500;
    else
      return w;
`else
    return w;
`endif
  endfunction

  logic [15:0] prescaler_p0;
  logic [15:0] frame_cnt_p0;
  logic [15:0] shadow_p0 [4];
  logic [15:0] active_p0 [4];
  logic        tick_p0;
  logic        wrap_p0;
  logic [3:0]  signal_p1;
  logic        frame_sync_p1;

  assign tick_p0 = (prescaler_p0 == TICK_LAST);
  assign wrap_p0 = tick_p0 && (frame_cnt_p0 == FRAME_LAST);

  // Stage p0: timebase, shadow writes and frame-boundary swap into the active set
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_p0 <= '0;
      frame_cnt_p0 <= '0;
      for (int i = 0; i < 4; i++) begin
        shadow_p0[i] <= RESET_VAL;
        active_p0[i] <= RESET_VAL;
      end
    end else begin
      prescaler_p0 <= tick_p0 ? 16'd0 : prescaler_p0 + 16'd1;
      if (tick_p0)
        frame_cnt_p0 <= wrap_p0 ? 16'd0 : frame_cnt_p0 + 16'd1;
      // Non-blocking update: a write on the wrap edge lands after active has taken the old shadow.
      if (wrap_p0)
        for (int i = 0; i < 4; i++)
          active_p0[i] <= shadow_p0[i];
      if (cs)
        shadow_p0[addr] <= clamp_width(data);
    end
  end

  // Stage p1: registered compare outputs and frame marker
  always_ff @(posedge clk) begin
    if (rst) begin
      signal_p1     <= '0;
      frame_sync_p1 <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        signal_p1[i] <= (frame_cnt_p0 < active_p0[i]);
      frame_sync_p1 <= wrap_p0;
    end
  end

  assign signal     = signal_p1;
  assign frame_sync = frame_sync_p1;

endmodule

// File: doc/servo_pwm_bank.md
SERVO_PWM_BANK -- requirements
Module: servo_pwm_bank

Interface
REQ-001 SHALL have parameter TICKS_PER_US, default 100, clk cycles per 1 us tick (2..65535).
REQ-002 SHALL have parameter FRAME_US, default 20000, frame period in us ticks (2..65535).
REQ-003 SHALL have parameter RESET_US, default 1500, pulse width loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cs  input  1  chip select; write strobe, sampled every clk edge.
REQ-007 SHALL have port addr  input  2  channel index 0..3.
REQ-008 SHALL have port data  input  16  pulse width in us.
REQ-009 SHALL have port signal  output  4  servo PWM outputs, bit i = channel i, registered.
REQ-010 SHALL have port frame_sync  output  1  one-cycle pulse at each frame boundary, registered.

Function
REQ-011 SHALL keep four 16-bit shadow registers and four 16-bit active registers.
REQ-012 On an edge with cs=1, shadow[addr] SHALL take data (after the REQ-030 clamp, if compiled in); other shadows hold.
REQ-013 cs held high SHALL rewrite shadow[addr] every cycle; there is no ack and no back-pressure.
REQ-014 Prescaler SHALL count 0..TICKS_PER_US-1 and wrap; tick = (prescaler == TICKS_PER_US-1).
REQ-015 Frame counter SHALL advance by 1 on tick and wrap from FRAME_US-1 to 0 on tick.
REQ-016 At the wrap edge, all active[i] SHALL load shadow[i], and frame_sync SHALL be 1 the following cycle only.
REQ-017 If a write and a wrap occur on the same edge, active[addr] SHALL take the pre-write shadow value; the new value SHALL take effect at the next wrap.
REQ-018 signal[i] SHALL be registered as (frame_cnt < active[i]), giving one clk of latency from the counter.
REQ-019 active[i]=0 SHALL hold signal[i] low for the entire frame.
REQ-020 active[i] >= FRAME_US SHALL hold signal[i] high for the entire frame, with no gap at the wrap.
REQ-021 A high pulse SHALL last exactly active[i]*TICKS_PER_US clk cycles and SHALL start on the cycle after frame_cnt returns to 0.
REQ-022 Changing a shadow register mid-frame SHALL NOT alter the current frame's output, so outputs are glitch-free.
REQ-023 All comparisons SHALL be unsigned 16-bit.

Reset
REQ-024 While rst=1 at an edge, prescaler and frame_cnt SHALL go to 0.
REQ-025 While rst=1 at an edge, shadow[i] and active[i] SHALL go to RESET_US.
REQ-026 While rst=1 at an edge, signal SHALL go to 4'b0000 and frame_sync to 0.
REQ-027 rst SHALL take priority over cs; a write on a reset edge SHALL be discarded.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; the first post-reset frame SHALL start with frame_cnt=0 and all channels at RESET_US.
REQ-029 No frame_sync pulse SHALL be produced for the reset-induced restart.

Configuration
REQ-030 With macro SERVO_PWM_CLAMP_EN defined, a written data value below 500 SHALL be stored as 500 and a value above 2500 SHALL be stored as 2500; values from 500 to 2500 SHALL be stored unchanged.
REQ-031 Without SERVO_PWM_CLAMP_EN, data SHALL be stored unmodified (0..65535); RESET_US SHALL never be clamped.

Verification (TICKS_PER_US=2, FRAME_US=100, RESET_US=10 unless stated)
REQ-032 Reset release -> all four signal bits high for exactly 20 clk per 200-clk frame; frame_sync pulses every 200 clk, none at reset.
REQ-033 Write ch2=30 at frame_cnt=40 -> ch2 stays at 20 clk this frame, becomes 60 clk next frame; ch0, ch1 and ch3 are unchanged.
REQ-034 Write ch1=0 and ch3=150 -> signal[1] low for the whole frame; signal[3] high continuously across the wrap.
REQ-035 Write ch0=50 on the exact wrap edge -> the next frame uses the old shadow value; the frame after that shows 100 clk high.
REQ-036 Assert rst for 1 clk at frame_cnt=70 with ch2=30 -> outputs are 0 the next cycle, the frame restarts, and all channels show 20 clk high.
REQ-037 Default params, SERVO_PWM_CLAMP_EN defined, write 100 and 3000 -> 500 us and 2500 us pulses; undefined -> 100 us and 3000 us pulses.
